// File: rtl/dav_pkg.sv
// Shared types and defaults for the FFT frame scheduler.
// Scheduler state encoding, timing defaults derived from the FFT pipeline depth, and a small state helper.
package dav_pkg;

  localparam int N_STAGES = 96;

  // Watchdog allows a third of the pipeline depth on top of the nominal latency.
  localparam int SCHED_TIMEOUT    = N_STAGES + N_STAGES / 3;
  localparam int SCHED_RST_CYCLES = N_STAGES / 24;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_WAIT,
    ST_START,
    ST_RUN,
    ST_RECOVER
  } sched_state_t;

  function automatic logic is_busy(sched_state_t s);
    return (s == ST_START) || (s == ST_RUN);
  endfunction

endpackage

// File: rtl/fft_frame_scheduler_toggle_sync.sv
// Brings a per-frame toggle into the local clock domain and emits a one-cycle req per change.
// Two synchronizer flops plus a history flop; req is registered so it is glitch-free downstream.
module toggle_sync (
  input  logic clk,
  input  logic rst,
  input  logic toggle,
  output logic req
);

  logic s1, s2, s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      s3  <= 1'b0;
      req <= 1'b0;
    end else begin
      s1  <= toggle;
      s2  <= s1;
      s3  <= s2;
      req <= s2 ^ s3;
    end
  end

endmodule

// File: rtl/fft_frame_scheduler.sv
// Sequences the FFT core per frame: start pulses, done tracking, watchdog recovery and debug counters.
// Optional build macro FFT_SCHED_PENDING_EN keeps one request pending while a frame is in flight.
module fft_frame_scheduler
  import dav_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = SCHED_TIMEOUT,
  parameter int RST_CYCLES     = SCHED_RST_CYCLES,
  parameter int DECIM          = 1,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_toggle,
  input  logic             enable,
  input  logic             fft_done,
  output logic             fft_start,
  output logic             fft_rst,
  output logic             busy,
  output logic             result_valid,
  output logic             bank,
  output logic [CNT_W-1:0] frames_done,
  output logic [CNT_W-1:0] overruns,
  output logic [CNT_W-1:0] timeouts
);

  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RC_W  = $clog2(RST_CYCLES + 1);
  localparam int DEC_W = $clog2(DECIM + 1);

  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(RST_CYCLES - 1);
  localparam logic [DEC_W-1:0] DEC_LAST = DEC_W'(DECIM - 1);

  sched_state_t     state, state_next;
  logic [WD_W-1:0]  wd_cnt;
  logic [RC_W-1:0]  rc_cnt;
  logic [DEC_W-1:0] dec_cnt, dec_next;
  logic             req;
  logic             done_d;
  logic             done_rise;
  logic             accept;
  logic             complete;
  logic             timeout_evt;
  logic             overrun_evt;
`ifdef FFT_SCHED_PENDING_EN
  logic             pending, pending_next;
`endif

  toggle_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .toggle (frame_toggle),
    .req    (req)
  );

  // Only a fresh rising edge counts, so a done level left over from the last frame is ignored.
  assign done_rise = fft_done && !done_d;

  always_comb begin
    state_next   = state;
    dec_next     = dec_cnt;
    fft_start    = 1'b0;
    fft_rst      = 1'b0;
    busy         = is_busy(state);
    result_valid = 1'b0;
    accept       = 1'b0;
    complete     = 1'b0;
    timeout_evt  = 1'b0;
    overrun_evt  = 1'b0;
`ifdef FFT_SCHED_PENDING_EN
    pending_next = pending;
`endif

    case (state)
      ST_INIT, ST_RECOVER: begin
        fft_rst     = 1'b1;
        overrun_evt = req;
        if (rc_cnt == RC_LAST) state_next = ST_WAIT;
      end

      ST_WAIT: begin
`ifdef FFT_SCHED_PENDING_EN
        accept       = pending || (req && enable);
        pending_next = 1'b0;
`else
        accept = req && enable;
`endif
        if (accept) begin
          if (dec_cnt == DEC_LAST) begin
            dec_next   = '0;
            state_next = ST_START;
          end else begin
            dec_next = dec_cnt + DEC_W'(1);
          end
        end
      end

      ST_START, ST_RUN: begin
        if (state == ST_START) begin
          fft_start  = 1'b1;
          state_next = ST_RUN;
        end else if (done_rise) begin
          result_valid = 1'b1;
          complete     = 1'b1;
          state_next   = ST_WAIT;
        end else if (wd_cnt == WD_LAST) begin
          timeout_evt = 1'b1;
          state_next  = ST_RECOVER;
        end
`ifdef FFT_SCHED_PENDING_EN
        if (timeout_evt) begin
          overrun_evt  = req;
          pending_next = 1'b0;
        end else if (req) begin
          if (pending) overrun_evt = 1'b1;
          else         pending_next = 1'b1;
        end
`else
        overrun_evt = req;
`endif
      end

      default: state_next = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_INIT;
      rc_cnt      <= '0;
      wd_cnt      <= '0;
      dec_cnt     <= '0;
      done_d      <= 1'b0;
      bank        <= 1'b0;
      frames_done <= '0;
      overruns    <= '0;
      timeouts    <= '0;
    end else begin
      state   <= state_next;
      rc_cnt  <= ((state == ST_INIT || state == ST_RECOVER) && state_next == state)
                 ? rc_cnt + RC_W'(1) : '0;
      wd_cnt  <= (state == ST_RUN) ? wd_cnt + WD_W'(1) : '0;
      dec_cnt <= dec_next;
      done_d  <= fft_done;
      bank    <= bank ^ complete;
      // Statistics saturate so a long-running board never shows a wrapped small count.
      if (complete && !(&frames_done)) frames_done <= frames_done + CNT_W'(1);
      if (overrun_evt && !(&overruns)) overruns <= overruns + CNT_W'(1);
      if (timeout_evt && !(&timeouts)) timeouts <= timeouts + CNT_W'(1);
    end
  end

`ifdef FFT_SCHED_PENDING_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending <= 1'b0;
    else     pending <= pending_next;
  end
`endif

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Self-checking bench for fft_frame_scheduler: frame table, scoreboarded start/result events, corner sequences.
// A second instance with DECIM=3 and 2-bit counters covers decimation and counter saturation.
module tb_fft_frame_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_toggle = 1'b0;
  logic        enable = 1'b1;
  logic        fft_done = 1'b0;
  logic        fft_start, fft_rst, busy, result_valid, bank;
  logic [15:0] frames_done, overruns, timeouts;

  logic        frame_toggle2 = 1'b0;
  logic        fft_start2, fft_rst2, busy2, result_valid2, bank2;
  logic [1:0]  frames_done2, overruns2, timeouts2;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct { logic b; int f; } res_t;
  int   start_q[$];
  res_t res_q[$];
  int   exp_cyc;
  res_t rec;

  int n_start = 0, n_valid = 0, rst_hi = 0, busy_hi = 0;
  int n_start2 = 0, n_valid2 = 0, rst2_hi = 0, busy2_hi = 0;
  bit pend_push = 1'b0;

  int model_lat = 0;
  int model_cnt = 0;

  typedef struct { bit en; int lat; bit cmp; bit b; int f; int t; } vec_t;
  vec_t tbl [10];

  fft_frame_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .frame_toggle (frame_toggle),
    .enable       (enable),
    .fft_done     (fft_done),
    .fft_start    (fft_start),
    .fft_rst      (fft_rst),
    .busy         (busy),
    .result_valid (result_valid),
    .bank         (bank),
    .frames_done  (frames_done),
    .overruns     (overruns),
    .timeouts     (timeouts)
  );

  fft_frame_scheduler #(.DECIM(3), .CNT_W(2)) dut2 (
    .clk          (clk),
    .rst          (rst),
    .frame_toggle (frame_toggle2),
    .enable       (1'b1),
    .fft_done     (1'b0),
    .fft_start    (fft_start2),
    .fft_rst      (fft_rst2),
    .busy         (busy2),
    .result_valid (result_valid2),
    .bank         (bank2),
    .frames_done  (frames_done2),
    .overruns     (overruns2),
    .timeouts     (timeouts2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check_output(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // FFT core model: restarts on fft_start, drops a stale done 10 cycles in, raises done after model_lat cycles.
  always @(negedge clk) begin
    if (fft_start) begin
      model_cnt = model_lat;
      if (model_lat == 0) fft_done = 1'b0;
    end else if (model_cnt != 0) begin
      model_cnt--;
      if (model_lat > 10 && model_cnt == model_lat - 10) fft_done = 1'b0;
      if (model_cnt == 0) fft_done = 1'b1;
    end
  end

  // Scoreboard monitor, sampling late in the low phase so combinational pulses are settled.
  always @(negedge clk) begin
    #3;
    if (fft_start) begin
      n_start++;
      if (start_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL start_unexpected actual=1 expected=0 (cycle %0d)", cyc);
      end else begin
        exp_cyc = start_q.pop_front();
        check_output("start_cycle", cyc, exp_cyc);
      end
    end
    if (result_valid) begin
      n_valid++;
      if (pend_push) begin
        pend_push = 1'b0;
        start_q.push_back(cyc + 2);
      end
      if (res_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL valid_unexpected actual=1 expected=0 (cycle %0d)", cyc);
      end else begin
        rec = res_q.pop_front();
        check_output("valid_bank_pre", bank, rec.b);
        check_output("valid_frames_pre", frames_done, rec.f);
      end
    end
    if (fft_rst)       rst_hi++;
    if (busy)          busy_hi++;
    if (fft_start2)    n_start2++;
    if (result_valid2) n_valid2++;
    if (fft_rst2)      rst2_hi++;
    if (busy2)         busy2_hi++;
  end

  task automatic apply_stimulus(input vec_t v, input int idx);
    int s0, v0, eb;
    s0 = n_start;
    v0 = n_valid;
    if (!v.en)                        eb = 0;
    else if (v.lat == 0 || v.lat > 128) eb = 129;
    else                              eb = v.lat + 1;
    @(negedge clk);
    rst_hi    = 0;
    busy_hi   = 0;
    model_lat = v.lat;
    enable    = v.en;
    if (v.en) start_q.push_back(cyc + 4);
    if (v.cmp) res_q.push_back('{b: ~v.b, f: v.f - 1});
    frame_toggle = ~frame_toggle;
    repeat (150) @(negedge clk);
    #3;
    $display("[TB] vector %0d en=%0d lat=%0d", idx, v.en, v.lat);
    check_output("vec_bank", bank, v.b);
    check_output("vec_frames", frames_done, v.f);
    check_output("vec_timeouts", timeouts, v.t);
    check_output("vec_overruns", overruns, 0);
    check_output("vec_starts", n_start - s0, v.en);
    check_output("vec_valids", n_valid - v0, v.cmp);
    check_output("vec_rst_cycles", rst_hi, (v.en && !v.cmp) ? 4 : 0);
    check_output("vec_busy_cycles", busy_hi, eb);
    check_output("vec_start_pending", start_q.size(), 0);
  endtask

  task automatic toggle2(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      frame_toggle2 = ~frame_toggle2;
      repeat (7) @(negedge clk);
    end
  endtask

  initial begin
    int s0;
    tbl[0] = '{en: 1, lat: 96,  cmp: 1, b: 1, f: 1, t: 0};
    tbl[1] = '{en: 1, lat: 96,  cmp: 1, b: 0, f: 2, t: 0};
    tbl[2] = '{en: 0, lat: 96,  cmp: 0, b: 0, f: 2, t: 0};
    tbl[3] = '{en: 1, lat: 0,   cmp: 0, b: 0, f: 2, t: 1};
    tbl[4] = '{en: 1, lat: 50,  cmp: 1, b: 1, f: 3, t: 1};
    tbl[5] = '{en: 1, lat: 128, cmp: 1, b: 0, f: 4, t: 1};
    tbl[6] = '{en: 1, lat: 129, cmp: 0, b: 0, f: 4, t: 2};
    tbl[7] = '{en: 1, lat: 127, cmp: 1, b: 1, f: 5, t: 2};
    tbl[8] = '{en: 0, lat: 96,  cmp: 0, b: 1, f: 5, t: 2};
    tbl[9] = '{en: 1, lat: 0,   cmp: 0, b: 1, f: 5, t: 3};

    // Reset values, then fft_rst held for exactly four cycles after release.
    repeat (3) @(negedge clk);
    #3;
    check_output("rst_fft_rst", fft_rst, 1);
    check_output("rst_fft_start", fft_start, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_valid", result_valid, 0);
    check_output("rst_bank", bank, 0);
    check_output("rst_frames", frames_done, 0);
    check_output("rst_overruns", overruns, 0);
    check_output("rst_timeouts", timeouts, 0);
    @(negedge clk);
    rst    = 1'b0;
    rst_hi = 0;
    repeat (8) @(negedge clk);
    #3;
    check_output("init_rst_cycles", rst_hi, 4);
    check_output("init_rst_low", fft_rst, 0);
    check_output("init_no_start", n_start, 0);

    for (int i = 0; i < 10; i++) apply_stimulus(tbl[i], i);

    // Toggle while RUN: overrun by default, pending restart when the feature is built in.
    s0 = n_start;
    @(negedge clk);
    enable    = 1'b1;
    model_lat = 96;
    start_q.push_back(cyc + 4);
    res_q.push_back('{b: 1'b1, f: 5});
    frame_toggle = ~frame_toggle;
    repeat (40) @(negedge clk);
`ifdef FFT_SCHED_PENDING_EN
    pend_push = 1'b1;
    res_q.push_back('{b: 1'b0, f: 6});
`endif
    frame_toggle = ~frame_toggle;
    repeat (250) @(negedge clk);
    #3;
`ifdef FFT_SCHED_PENDING_EN
    check_output("ovr_overruns", overruns, 0);
    check_output("ovr_frames", frames_done, 7);
    check_output("ovr_starts", n_start - s0, 2);
    check_output("ovr_bank", bank, 1);
`else
    check_output("ovr_overruns", overruns, 1);
    check_output("ovr_frames", frames_done, 6);
    check_output("ovr_starts", n_start - s0, 1);
    check_output("ovr_bank", bank, 0);
`endif

    // Reset in the middle of RUN, then a request that lands while INIT is still running.
    @(negedge clk);
    model_lat = 0;
    start_q.push_back(cyc + 4);
    frame_toggle = ~frame_toggle;
    repeat (30) @(negedge clk);
    rst = 1'b1;
    frame_toggle = 1'b1;
    #3;
    check_output("midrst_busy", busy, 0);
    check_output("midrst_fft_rst", fft_rst, 1);
    check_output("midrst_bank", bank, 0);
    check_output("midrst_frames", frames_done, 0);
    check_output("midrst_timeouts", timeouts, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    s0  = n_start;
    repeat (20) @(negedge clk);
    #3;
    check_output("init_req_overrun", overruns, 1);
    check_output("init_req_no_start", n_start - s0, 0);
    check_output("init_req_rst_low", fft_rst, 0);

    // Decimation by three and saturation of the 2-bit counters on the second instance.
    @(negedge clk);
    rst2_hi  = 0;
    busy2_hi = 0;
    toggle2(2);
    #3;
    check_output("decim_two_no_start", n_start2, 0);
    toggle2(1);
    repeat (150) @(negedge clk);
    toggle2(3);
    repeat (150) @(negedge clk);
    #3;
    check_output("decim_starts", n_start2, 2);
    check_output("decim_timeouts", timeouts2, 2);
    toggle2(3);
    toggle2(5);
    repeat (150) @(negedge clk);
    #3;
    check_output("sat_overruns", overruns2, 3);
    check_output("sat_timeouts_at_max", timeouts2, 3);
    check_output("sat_starts", n_start2, 3);
    toggle2(3);
    repeat (150) @(negedge clk);
    #3;
    check_output("sat_timeouts_hold", timeouts2, 3);
    check_output("sat_starts_final", n_start2, 4);
    check_output("dut2_frames", frames_done2, 0);
    check_output("dut2_bank", bank2, 0);
    check_output("dut2_valids", n_valid2, 0);
    check_output("dut2_busy_cycles", busy2_hi, 516);
    check_output("dut2_rst_cycles", rst2_hi, 16);

    check_output("start_q_drained", start_q.size(), 0);
    check_output("res_q_drained", res_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
